// File: rtl/mips_cpu_pkg.sv
// Shared widths and ALU operation encoding for the MIPS CPU datapath slice.
package mips_cpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OP_W       = 5;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned V0_IDX     = 2;

    typedef enum logic [OP_W-1:0] {
        ALU_AND  = 5'd0,
        ALU_OR   = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_SUB  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLLV = 5'd9,
        ALU_SRLV = 5'd10,
        ALU_SRAV = 5'd11
    } aluop_t;

    // Variable shifts take their amount from operand A instead of the shamt field.
    function automatic logic is_var_shift(input logic [OP_W-1:0] op);
        return (op == ALU_SLLV) || (op == ALU_SRLV) || (op == ALU_SRAV);
    endfunction

endpackage

// File: rtl/mips_cpu_alu_unit.sv
// Combinational MIPS ALU: logic, add/sub, signed compare and shifts; undefined ops yield 0.
module mips_cpu_alu_unit
    import mips_cpu_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [SHAMT_W-1:0] sa,
    output logic [DATA_W-1:0]  result,
    output logic               zero
);

    aluop_t             op_e;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic               a_lt_b;

    assign op_e   = aluop_t'(op);
    assign shamt  = is_var_shift(op) ? a[SHAMT_W-1:0] : sa;
    assign sum    = a + b;
    assign diff   = a - b;
    assign a_lt_b = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (op_e)
            ALU_AND:            result = a & b;
            ALU_OR:             result = a | b;
            ALU_XOR:            result = a ^ b;
            ALU_ADD:            result = sum;
            ALU_SUB:            result = diff;
            ALU_SLT:            result = {{(DATA_W-1){1'b0}}, a_lt_b};
            ALU_SLL, ALU_SLLV:  result = b << shamt;
            ALU_SRL, ALU_SRLV:  result = b >> shamt;
            ALU_SRA, ALU_SRAV:  result = $unsigned($signed(b) >>> shamt);
            default:            result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_cpu_alu_regs.sv
// Register file (32x32, r0 hardwired to 0) plus ALU. Define REGFILE_BYPASS_EN to forward
// same-cycle write data to matching read ports.
module mips_cpu_alu_regs
    import mips_cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [REG_ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [REG_ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0]     rdDataA,
    input  logic [REG_ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0]     rdDataB,
    output logic [DATA_W-1:0]     register_v0,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [SHAMT_W-1:0]    sa,
    output logic [DATA_W-1:0]     result,
    output logic                  zero
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en_d;

    assign wr_en_d = write && (wrAddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[wrAddr] <= wrData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst so reset still forces every read port to 0.
    always_comb begin
        rdDataA = (rdAddrA == '0) ? '0 : regs_q[rdAddrA];
        rdDataB = (rdAddrB == '0) ? '0 : regs_q[rdAddrB];
        if (wr_en_d && !rst && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end
        if (wr_en_d && !rst && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end
    end
`else
    always_comb begin
        rdDataA = (rdAddrA == '0) ? '0 : regs_q[rdAddrA];
        rdDataB = (rdAddrB == '0) ? '0 : regs_q[rdAddrB];
    end
`endif

    assign register_v0 = regs_q[V0_IDX];

    mips_cpu_alu_unit u_alu (
        .op     (op),
        .a      (a),
        .b      (b),
        .sa     (sa),
        .result (result),
        .zero   (zero)
    );

endmodule

// File: tb/tb_mips_cpu_alu_regs.sv
// Self-checking bench for mips_cpu_alu_regs: reference model compared every cycle plus literal vectors.
module tb_mips_cpu_alu_regs;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [4:0]  rdAddrA = '0;
    logic [4:0]  rdAddrB = '0;
    logic [31:0] rdDataA, rdDataB, register_v0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  sa = '0;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic [31:0] model_regs [32];

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    mips_cpu_alu_regs dut (
        .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .register_v0(register_v0), .op(op), .a(a), .b(b), .sa(sa),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] model_alu(input logic [4:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [4:0] s);
        int amt;
        amt = (o >= 9 && o <= 11) ? int'(x % 32) : int'(s);
        case (o)
            5'd0:  return x & y;
            5'd1:  return x | y;
            5'd2:  return x + y;
            5'd3:  return x - y;
            5'd4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd5:  return x ^ y;
            5'd6, 5'd9:  return y << amt;
            5'd7, 5'd10: return y >> amt;
            5'd8, 5'd11: return y[31] ? ~((~y) >> amt) : (y >> amt);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (BYPASS && !rst && write && wrAddr != 0 && wrAddr == addr) return wrData;
        return model_regs[addr];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
        end else if (write && wrAddr != 0) begin
            model_regs[wrAddr] = wrData;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_res;
            exp_res = model_alu(op, a, b, sa);
            check("cyc_rdDataA", rdDataA, model_read(rdAddrA));
            check("cyc_rdDataB", rdDataB, model_read(rdAddrB));
            check("cyc_v0", register_v0, model_regs[2]);
            check("cyc_result", result, exp_res);
            check("cyc_zero", {31'd0, zero}, {31'd0, exp_res == 0});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input logic [4:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] s, input logic [31:0] exp);
        op = o; a = x; b = y; sa = s;
        #2;
        check(name, result, exp);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, exp == 0});
        step();
    endtask

    initial begin
        rdAddrA = 5'd2;
        step();
        step();
        check("rst_v0", register_v0, 32'h0);
        check("rst_rdA", rdDataA, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Write r2, then attempt to write r0.
        write = 1'b1; wrAddr = 5'd2; wrData = 32'hDEADBEEF;
        step();
        wrAddr = 5'd0; wrData = 32'hFFFFFFFF; rdAddrA = 5'd2; rdAddrB = 5'd0;
        #2;
        check("wr_r2", rdDataA, 32'hDEADBEEF);
        check("wr_v0", register_v0, 32'hDEADBEEF);
        check("wr_r0_pre", rdDataB, 32'h0);
        step();
        write = 1'b0;
        #2;
        check("wr_r0_post", rdDataB, 32'h0);
        check("wr_r2_keep", rdDataA, 32'hDEADBEEF);

        // Same-cycle write/read hazard on r5.
        step();
        write = 1'b1; wrAddr = 5'd5; wrData = 32'd7; rdAddrA = 5'd5;
        #2;
        check("hazard_pre", rdDataA, BYPASS ? 32'd7 : 32'd0);
        step();
        write = 1'b0;
        #2;
        check("hazard_post", rdDataA, 32'd7);

        // Mid-cycle reset after writing r2.
        step();
        write = 1'b1; wrAddr = 5'd2; wrData = 32'h12345678; rdAddrA = 5'd2;
        step();
        write = 1'b0;
        #1;
        check("pre_rst_v0", register_v0, 32'h12345678);
        rst = 1'b1;
        #1;
        check("mid_rst_v0", register_v0, 32'h0);
        check("mid_rst_rdA", rdDataA, 32'h0);

        // Write coincident with reset is dropped; first write after release lands.
        write = 1'b1; wrAddr = 5'd3; wrData = 32'h000000AA; rdAddrB = 5'd3;
        step();
        #1;
        check("rst_blocks_wr", rdDataB, 32'h0);
        rst = 1'b0;
        step();
        write = 1'b0;
        #2;
        check("post_rst_wr", rdDataB, 32'h000000AA);
        step();

        run_vec("add_wrap",  5'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000);
        run_vec("sub",       5'd3,  32'd3,        32'd5,        5'd0,  32'hFFFFFFFE);
        run_vec("slt_neg",   5'd4,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1);
        run_vec("slt_pos",   5'd4,  32'd1,        32'hFFFFFFFF, 5'd0,  32'd0);
        run_vec("sra4",      5'd8,  32'h0,        32'h80000000, 5'd4,  32'hF8000000);
        run_vec("srl4",      5'd7,  32'h0,        32'h80000000, 5'd4,  32'h08000000);
        run_vec("sllv",      5'd9,  32'h00000021, 32'd1,        5'd0,  32'd2);
        run_vec("srav0",     5'd11, 32'h0,        32'h80000000, 5'd7,  32'h80000000);
        run_vec("and",       5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000);
        run_vec("xor_eq",    5'd5,  32'h12345678, 32'h12345678, 5'd0,  32'h0);
        run_vec("undef15",   5'd15, 32'd1,        32'd1,        5'd0,  32'h0);
        run_vec("or",        5'd1,  32'h0F0F0000, 32'h000000F0, 5'd0,  32'h0F0F00F0);
        run_vec("sll31",     5'd6,  32'h0,        32'd1,        5'd31, 32'h80000000);
        run_vec("sra31",     5'd8,  32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF);
        run_vec("srl0",      5'd7,  32'h0,        32'h80000000, 5'd0,  32'h80000000);
        run_vec("srlv_hi",   5'd10, 32'hFFFFFFE4, 32'hF0000000, 5'd0,  32'h0F000000);
        run_vec("undef31",   5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h0);

        // ALU stays live during reset.
        op = 5'd2; a = 32'd40; b = 32'd2;
        rst = 1'b1;
        #2;
        check("alu_in_rst", result, 32'd42);
        step();
        rst = 1'b0;
        step();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_alu_regs.md
MIPS_CPU_ALU_REGS -- requirements
Module: mips_cpu_alu_regs

Interface
REQ-001 Parameters: none; all widths fixed (data 32, register address 5, opcode 5, shift amount 5).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 write  input  1  register-file write enable.
REQ-005 wrAddr  input  5  write register index.
REQ-006 wrData  input  32  write data.
REQ-007 rdAddrA  input  5  read port A index.
REQ-008 rdDataA  output  32  read port A data.
REQ-009 rdAddrB  input  5  read port B index.
REQ-010 rdDataB  output  32  read port B data.
REQ-011 register_v0  output  32  continuous copy of register 2 ($v0).
REQ-012 op  input  5  ALU operation code.
REQ-013 a  input  32  ALU operand A (rs value).
REQ-014 b  input  32  ALU operand B (rt value or sign-extended immediate).
REQ-015 sa  input  5  shift amount (instruction shamt field).
REQ-016 result  output  32  ALU result.
REQ-017 zero  output  1  high when result == 0.

Function
REQ-018 Register file SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0.
REQ-019 Reads SHALL be combinational: rdDataA/rdDataB reflect stored value of the addressed register in the same cycle, zero latency.
REQ-020 On rising clk with write=1 and wrAddr!=0, wrData SHALL be stored; writes to register 0 SHALL be ignored.
REQ-021 Same-cycle write and read of one register SHALL return the old value until the edge; new value visible after the edge (unless REQ-036 applies).
REQ-022 register_v0 SHALL equal stored register 2 at all times, updating right after the writing edge.
REQ-023 ALU SHALL be purely combinational; all arithmetic modulo 2^32, no overflow flag, no trap.
REQ-024 op 0 AND: a & b. op 1 OR: a | b. op 5 XOR: a ^ b.
REQ-025 op 2 ADD: a + b. op 3 SUB: a - b.
REQ-026 op 4 SLT: 1 if a < b as signed two's complement, else 0.
REQ-027 op 6 SLL: b << sa. op 7 SRL: b >> sa logical. op 8 SRA: b >> sa arithmetic (sign bit replicated).
REQ-028 op 9 SLLV, 10 SRLV, 11 SRAV: as ops 6/7/8 with shift amount a[4:0]; a[31:5] ignored.
REQ-029 Shift amount 0 SHALL return b unchanged; 31 is the maximum.
REQ-030 op 12..31 (undefined) SHALL give result 0 (so zero=1).
REQ-031 zero SHALL be derived from result for every op.

Reset
REQ-032 While rst=1, all 32 registers SHALL clear to 0 immediately, independent of clk; register_v0, rdDataA, rdDataB SHALL read 0.
REQ-033 rst SHALL override a coincident write; a write on the first edge after rst deasserts SHALL take effect.
REQ-034 ALU has no state; result/zero unaffected by rst.

Configuration
REQ-035 Macro REGFILE_BYPASS_EN SHALL select write-forwarding.
REQ-036 With REGFILE_BYPASS_EN defined: when write=1, wrAddr!=0 and wrAddr equals a read address, that read port SHALL return wrData combinationally in the same cycle.
REQ-037 Without it: behaviour exactly per REQ-021, no forwarding.

Structure
REQ-038 Package mips_cpu_pkg SHALL hold the aluop_t enum (AND=0 ... SRAV=11, 5-bit) and width constants; the module and benches SHALL import it.
REQ-039 ALU SHALL be the one sub-module, mips_cpu_alu_unit (ports op,a,b,sa,result,zero); register file inline in the top.

Verification
REQ-040 Reset: pulse rst mid-cycle after writing 0x12345678 to r2 -> register_v0 and rdDataA(r2) read 0 before next edge.
REQ-041 Write/read: write 0xDEADBEEF to r2, then write 0xFFFFFFFF to r0 -> r2 reads 0xDEADBEEF, register_v0=0xDEADBEEF, r0 reads 0.
REQ-042 Same-cycle hazard: write r5=7 while rdAddrA=5 (old 0) -> rdDataA=0 before edge without macro, 7 with REGFILE_BYPASS_EN.
REQ-043 Arithmetic: ADD 0xFFFFFFFF+1 -> 0, zero=1; SUB 3-5 -> 0xFFFFFFFE; SLT a=0xFFFFFFFF,b=1 -> 1; SLT a=1,b=0xFFFFFFFF -> 0.
REQ-044 Shifts: SRA b=0x80000000,sa=4 -> 0xF8000000; SRL same -> 0x08000000; SLLV a=0x00000021,b=1 -> 2; SRAV a=0,b=0x80000000 -> 0x80000000.
REQ-045 Logic/undefined: AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000; XOR equal operands -> 0, zero=1; op=15 -> result 0.
